// File: rtl/cam_pwr_seq.sv
// Camera sensor power-up sequencer: lock filter, then timed PWDN/RESET release and seq_ready.
// Optional macro CAMSEQ_XCLK_GATE_EN adds cam_xclk_en, which runs the sensor XCLK whenever the FSM has left WAIT_LOCK.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_LOCK | sensor held off; counting consecutive synchronised lock cycles
// PWDN_HOLD | lock qualified; cam_pwdn still high for T_PWDN cycles
// RST_HOLD  | cam_pwdn low; cam_reset_n still low for T_RST cycles
// INIT_WAIT | cam_reset_n high; sensor internal init for T_INIT cycles
// READY     | sensor may be configured; held until lock loss/restart/reset
module cam_pwr_seq #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOCK_FILT = 16,
  parameter int unsigned T_PWDN    = 1000,
  parameter int unsigned T_RST     = 1000,
  parameter int unsigned T_INIT    = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       cam_pwdn,
  output logic       cam_reset_n,
  output logic       seq_ready,
  output logic       lock_lost,
  output logic [2:0] seq_state
`ifdef CAMSEQ_XCLK_GATE_EN
  ,
  output logic       cam_xclk_en
`endif
);

  localparam logic [2:0] ST_WAIT  = 3'd0;
  localparam logic [2:0] ST_PWDN  = 3'd1;
  localparam logic [2:0] ST_RST   = 3'd2;
  localparam logic [2:0] ST_INIT  = 3'd3;
  localparam logic [2:0] ST_READY = 3'd4;

  // A zero-length interval is treated as one cycle.
  function automatic logic [CNT_W-1:0] f_tc(input int unsigned t);
    return (t == 0) ? '0 : CNT_W'(t - 32'd1);
  endfunction

  localparam logic [CNT_W-1:0] TC_FILT = f_tc(LOCK_FILT);
  localparam logic [CNT_W-1:0] TC_PWDN = f_tc(T_PWDN);
  localparam logic [CNT_W-1:0] TC_RST  = f_tc(T_RST);
  localparam logic [CNT_W-1:0] TC_INIT = f_tc(T_INIT);

  logic             r_lock_meta;
  logic             r_lock_s;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pwdn;
  logic             r_rstn;
  logic             r_ready;
  logic             r_lost;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_lost_nxt;
  logic             w_lock_loss;
  logic             w_pwdn_nxt;
  logic             w_rstn_nxt;
  logic             w_ready_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Outputs are registered from the next-state decode so they move with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
      r_pwdn  <= 1'b1;
      r_rstn  <= 1'b0;
      r_ready <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pwdn  <= w_pwdn_nxt;
      r_rstn  <= w_rstn_nxt;
      r_ready <= w_ready_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  assign w_lock_loss = !r_lock_s && (r_state inside {ST_PWDN, ST_RST, ST_INIT, ST_READY});

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_lost_nxt  = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (!r_lock_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == TC_FILT) begin
          w_state_nxt = ST_PWDN;
          w_cnt_nxt   = '0;
        end
      end
      ST_PWDN: begin
        if (r_cnt == TC_PWDN) begin
          w_state_nxt = ST_RST;
          w_cnt_nxt   = '0;
        end
      end
      ST_RST: begin
        if (r_cnt == TC_RST) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_INIT: begin
        if (r_cnt == TC_INIT) begin
          w_state_nxt = ST_READY;
          w_cnt_nxt   = '0;
        end
      end
      ST_READY: w_cnt_nxt = '0;
      default: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
    endcase
    if (restart) begin
      w_state_nxt = ST_WAIT;
      w_cnt_nxt   = '0;
    end
    // Lock loss wins over both restart and a same-cycle advance, and is the only source of the pulse.
    if (w_lock_loss) begin
      w_state_nxt = ST_WAIT;
      w_cnt_nxt   = '0;
      w_lost_nxt  = 1'b1;
    end
  end

  always_comb begin
    w_pwdn_nxt  = 1'b1;
    w_rstn_nxt  = 1'b0;
    w_ready_nxt = 1'b0;
    case (w_state_nxt)
      ST_RST: w_pwdn_nxt = 1'b0;
      ST_INIT: begin
        w_pwdn_nxt = 1'b0;
        w_rstn_nxt = 1'b1;
      end
      ST_READY: begin
        w_pwdn_nxt  = 1'b0;
        w_rstn_nxt  = 1'b1;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_pwdn_nxt  = 1'b1;
        w_rstn_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

`ifdef CAMSEQ_XCLK_GATE_EN
  logic r_xclk;
  logic w_xclk_nxt;

  // XCLK must be running before cam_pwdn falls, so it is enabled from PWDN_HOLD onward.
  assign w_xclk_nxt = (w_state_nxt inside {ST_PWDN, ST_RST, ST_INIT, ST_READY});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_xclk <= 1'b0;
    else          r_xclk <= w_xclk_nxt;
  end

  assign cam_xclk_en = r_xclk;
`endif

  assign cam_pwdn    = r_pwdn;
  assign cam_reset_n = r_rstn;
  assign seq_ready   = r_ready;
  assign lock_lost   = r_lost;
  assign seq_state   = r_state;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Bench for cam_pwr_seq: expected output transitions are queued with their cycle when stimulus is
// driven; a negedge monitor pops each observed transition against the queue.
module tb_cam_pwr_seq;
  localparam int LF = 4;
  localparam int TP = 8;
  localparam int TR = 6;
  localparam int TI = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       restart;
  logic       cam_pwdn;
  logic       cam_reset_n;
  logic       seq_ready;
  logic       lock_lost;
  logic [2:0] seq_state;
  logic       cam_xclk_en;

  cam_pwr_seq #(
    .CNT_W(16), .LOCK_FILT(LF), .T_PWDN(TP), .T_RST(TR), .T_INIT(TI)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .restart(restart),
    .cam_pwdn(cam_pwdn), .cam_reset_n(cam_reset_n), .seq_ready(seq_ready),
    .lock_lost(lock_lost), .seq_state(seq_state)
`ifdef CAMSEQ_XCLK_GATE_EN
    , .cam_xclk_en(cam_xclk_en)
`endif
  );

`ifndef CAMSEQ_XCLK_GATE_EN
  assign cam_xclk_en = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {int code; int val; int cyc;} ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  int  prev [6];
  int  cur  [6];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string nm(input int code);
    case (code)
      0: return "lock_lost";
      1: return "cam_pwdn";
      2: return "cam_reset_n";
      3: return "seq_ready";
      4: return "seq_state";
      default: return "cam_xclk_en";
    endcase
  endfunction

  // {cam_pwdn, cam_reset_n, seq_ready, cam_xclk_en} for each state
  function automatic logic [3:0] outs(input int s);
    case (s)
      0: return 4'b1000;
      1: return 4'b1001;
      2: return 4'b0001;
      3: return 4'b0101;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic push_state(input int ps, input int ns, input int c);
    logic [3:0] o, n;
    o = outs(ps);
    n = outs(ns);
    if (o[3] != n[3]) exp_q.push_back('{1, int'(n[3]), c});
    if (o[2] != n[2]) exp_q.push_back('{2, int'(n[2]), c});
    if (o[1] != n[1]) exp_q.push_back('{3, int'(n[1]), c});
`ifdef CAMSEQ_XCLK_GATE_EN
    if (o[0] != n[0]) exp_q.push_back('{5, int'(n[0]), c});
`endif
    exp_q.push_back('{4, ns, c});
  endtask

  task automatic push_lost(input int c);
    exp_q.push_back('{0, 1, c});
    exp_q.push_back('{0, 0, c + 1});
  endtask

  // p = edge on which PWDN_HOLD is entered
  task automatic push_seq(input int p);
    push_state(0, 1, p);
    push_state(1, 2, p + TP);
    push_state(2, 3, p + TP + TR);
    push_state(3, 4, p + TP + TR + TI);
  endtask

  task automatic run_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    int idx;
    cur[0] = int'(lock_lost);
    cur[1] = int'(cam_pwdn);
    cur[2] = int'(cam_reset_n);
    cur[3] = int'(seq_ready);
    cur[4] = int'(seq_state);
    cur[5] = int'(cam_xclk_en);
    if (mon_en) begin
      for (int k = 0; k < 6; k++) begin
        if (cur[k] != prev[k]) begin
          idx = -1;
          for (int j = 0; j < exp_q.size(); j++)
            if (idx < 0 && exp_q[j].code == k && exp_q[j].val == cur[k] && exp_q[j].cyc == cyc) idx = j;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL %s: changed to %0d at cycle %0d, no such transition expected", nm(k), cur[k], cyc);
          end else begin
            exp_q.delete(idx);
          end
        end
      end
    end
    prev = cur;
  end

  task automatic test_reset;
    reset_n = 1'b1; pll_lock = 1'b0; restart = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (cam_pwdn !== 1'b1) begin errors++; $display("FAIL reset_pwdn: got %b want 1", cam_pwdn); end
    checks++; if (cam_reset_n !== 1'b0) begin errors++; $display("FAIL reset_rstn: got %b want 0", cam_reset_n); end
    checks++; if (seq_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", seq_ready); end
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b want 0", lock_lost); end
    checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", seq_state); end
    checks++; if (cam_xclk_en !== 1'b0) begin errors++; $display("FAIL reset_xclk: got %b want 0", cam_xclk_en); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
    run_to(cyc + 8);
    checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL idle_no_lock: state %0d want 0", seq_state); end
  endtask

  task automatic test_nominal;
    int c;
    c = cyc;
    pll_lock = 1'b1;
    push_seq(c + 2 + LF);
    run_to(c + 2 + LF + TP + TR + TI - 1);
    checks++; if (seq_ready !== 1'b0) begin errors++; $display("FAIL nominal_ready_early: got %b want 0", seq_ready); end
    run_to(c + 2 + LF + TP + TR + TI + 3);
    checks++; if (seq_ready !== 1'b1) begin errors++; $display("FAIL nominal_ready: got %b want 1", seq_ready); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL nominal: %0d transitions not seen, first %s->%0d at cycle %0d", exp_q.size(), nm(exp_q[0].code), exp_q[0].val, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_lock_loss_ready;
    int c;
    c = cyc;
    pll_lock = 1'b0;
    push_state(4, 0, c + 3);
    push_lost(c + 3);
    push_seq(c + 3 + LF);
    @(negedge clk);
    pll_lock = 1'b1;
    run_to(c + 3);
    checks++;
    if (seq_state !== 3'd0 || cam_pwdn !== 1'b1 || cam_reset_n !== 1'b0 || seq_ready !== 1'b0 || lock_lost !== 1'b1) begin
      errors++;
      $display("FAIL loss_ready_outputs: state=%0d pwdn=%b rstn=%b ready=%b lost=%b want 0 1 0 0 1",
               seq_state, cam_pwdn, cam_reset_n, seq_ready, lock_lost);
    end
    run_to(c + 3 + LF + TP + TR + TI + 3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL loss_ready: %0d transitions not seen, first %s->%0d at cycle %0d", exp_q.size(), nm(exp_q[0].code), exp_q[0].val, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_restart_rst_hold;
    int c;
    c = cyc;
    restart = 1'b1;
    push_state(4, 0, c + 1);
    push_state(0, 1, c + 1 + LF);
    push_state(1, 2, c + 1 + LF + TP);
    @(negedge clk);
    restart = 1'b0;
    run_to(c + 1 + LF + TP + 2);
    checks++; if (seq_state !== 3'd2) begin errors++; $display("FAIL restart_setup: state %0d want 2", seq_state); end
    c = cyc;
    restart = 1'b1;
    push_state(2, 0, c + 1);
    push_seq(c + 1 + LF);
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if (seq_state !== 3'd0 || cam_pwdn !== 1'b1 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL restart_rst: state=%0d pwdn=%b lost=%b want 0 1 0", seq_state, cam_pwdn, lock_lost);
    end
    run_to(c + 1 + 28);
    checks++; if (seq_ready !== 1'b1) begin errors++; $display("FAIL restart_latency: ready %b want 1 after 28 cycles", seq_ready); end
    run_to(c + 1 + 28 + 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart: %0d transitions not seen, first %s->%0d at cycle %0d", exp_q.size(), nm(exp_q[0].code), exp_q[0].val, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_lock_glitch;
    int c, g;
    c = cyc;
    pll_lock = 1'b0;
    push_state(4, 0, c + 3);
    push_lost(c + 3);
    run_to(c + 6);
    g = cyc + 1;
    pll_lock = 1'b1;
    run_to(g + 2);
    pll_lock = 1'b0;
    run_to(g + 3);
    pll_lock = 1'b1;
    // lock_s re-rises after edge g+5; filter then PWDN_HOLD give the fall at g+5+LF+TP
    push_seq(g + 5 + LF);
    run_to(g + 5 + LF + TP + TR + TI + 3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch: %0d transitions not seen, first %s->%0d at cycle %0d", exp_q.size(), nm(exp_q[0].code), exp_q[0].val, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_restart_and_loss_init;
    int c, c2;
    c = cyc;
    restart = 1'b1;
    push_state(4, 0, c + 1);
    push_state(0, 1, c + 1 + LF);
    push_state(1, 2, c + 1 + LF + TP);
    push_state(2, 3, c + 1 + LF + TP + TR);
    @(negedge clk);
    restart = 1'b0;
    run_to(c + 1 + LF + TP + TR + 2);
    c2 = cyc;
    pll_lock = 1'b0;
    push_state(3, 0, c2 + 3);
    push_lost(c2 + 3);
    push_state(0, 1, c2 + 3 + LF);
    @(negedge clk);
    pll_lock = 1'b1;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++; if (lock_lost !== 1'b1 || seq_state !== 3'd0) begin errors++; $display("FAIL simul_loss: lost=%b state=%0d want 1 0", lock_lost, seq_state); end
    run_to(c2 + 3 + LF + 1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul: %0d transitions not seen, first %s->%0d at cycle %0d", exp_q.size(), nm(exp_q[0].code), exp_q[0].val, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  // Entered with the FSM one cycle into PWDN_HOLD; lock_s drops exactly on its terminal cycle.
  task automatic test_loss_final_cycle;
    int p, x;
    p = cyc - 1;
    x = p + TP - 3;
    run_to(x);
    pll_lock = 1'b0;
    push_state(1, 0, x + 3);
    push_lost(x + 3);
    push_state(0, 1, x + 3 + LF);
    @(negedge clk);
    pll_lock = 1'b1;
    run_to(x + 3);
    checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL final_cycle_prio: state %0d want 0", seq_state); end
    run_to(x + 3 + LF + 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_cycle: %0d transitions not seen, first %s->%0d at cycle %0d", exp_q.size(), nm(exp_q[0].code), exp_q[0].val, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_async_reset;
    checks++; if (seq_state !== 3'd1) begin errors++; $display("FAIL async_setup: state %0d want 1", seq_state); end
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL async_state: got %0d want 0", seq_state); end
    checks++; if (cam_pwdn !== 1'b1 || cam_reset_n !== 1'b0) begin errors++; $display("FAIL async_pins: pwdn=%b rstn=%b want 1 0", cam_pwdn, cam_reset_n); end
    checks++; if (seq_ready !== 1'b0 || lock_lost !== 1'b0) begin errors++; $display("FAIL async_flags: ready=%b lost=%b want 0 0", seq_ready, lock_lost); end
    checks++; if (cam_xclk_en !== 1'b0) begin errors++; $display("FAIL async_xclk: got %b want 0", cam_xclk_en); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_nominal;
    test_lock_loss_ready;
    test_restart_rst_hold;
    test_lock_glitch;
    test_restart_and_loss_init;
    test_loss_final_cycle;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
